// File: rtl/bus_swap_pkg.sv
// Shared types for the bus-based register transfer controller.
//   op_e    : command opcodes as encoded on the op input
//   state_e : controller sequencing states
package bus_swap_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_MOVE  = 2'b01,
      OP_SWAP  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      T3   = 3'd3,
      FIN  = 3'd4
   } state_e;

endpackage

// File: rtl/bus_swap_unit_reg_bank.sv
// Register bank on the shared bus: NUM_REGS data registers plus TMP at
// index NUM_REGS.
//   clk, rst  : clock, synchronous active-low clear of every register
//   ld        : one-hot capture strobe, selected register takes bus_data
//   bus_data  : shared bus value
//   oe        : one-hot driver select, oe_data is the selected register
//   rd_sel    : read-port index, rd_data is 0 for indices past the data regs
module reg_bank
   import bus_swap_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_REGS:0] ld,
   input  logic [DATA_W-1:0] bus_data,
   input  logic [NUM_REGS:0] oe,
   output logic [DATA_W-1:0] oe_data,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] regs [NUM_REGS+1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i <= NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i <= NUM_REGS; i++) begin
            if (ld[i]) regs[i] <= bus_data;
         end
      end
   end

   // AND-OR mux: oe is one-hot, so no priority is needed.
   always_comb begin
      oe_data = '0;
      for (int i = 0; i <= NUM_REGS; i++) begin
         if (oe[i]) oe_data = oe_data | regs[i];
      end
   end

   // TMP is deliberately not reachable from the read port.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_sel == SEL_W'(i)) rd_data = regs[i];
      end
   end

endmodule

// File: rtl/bus_swap_unit.sv
// Register transfer controller: runs LOAD/MOVE/SWAP/CLEAR over a shared
// one-hot bus into its own register bank, with start/done host handshake.
//   start, op, src_sel, dst_sel, ext_data : command, sampled in IDLE
//   rd_sel, rd_data : combinational read port into the data registers
//   busy, done, err : status; err qualifies the done pulse
//   bus_oe, bus_ld  : one-hot bus driver / capture strobes (bit NUM_REGS = TMP)
//
// state | meaning
// IDLE  | waiting for start
// T1    | index check; single transfer, or R[dst] -> TMP for SWAP
// T2    | SWAP: R[src] -> R[dst]
// T3    | SWAP: TMP -> R[src]
// FIN   | done pulse, no transfer
module bus_swap_unit
   import bus_swap_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 4,
   localparam int SEL_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [SEL_W-1:0]  src_sel,
   input  logic [SEL_W-1:0]  dst_sel,
   input  logic [DATA_W-1:0] ext_data,
   input  logic [SEL_W-1:0]  rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [NUM_REGS:0] bus_oe,
   output logic [NUM_REGS:0] bus_ld
);

   localparam logic [SEL_W:0]    N_LIM  = (SEL_W+1)'(NUM_REGS);
   localparam logic [NUM_REGS:0] TMP_OH = {1'b1, {NUM_REGS{1'b0}}};

   state_e              state_q, state_nxt;
   op_e                 op_q;
   logic [SEL_W-1:0]    src_q, dst_q;
   logic [DATA_W-1:0]   data_q;
   logic                err_q;
   logic                cmd_ok;
   logic [NUM_REGS:0]   oe, ld;
   logic [DATA_W-1:0]   bus_data, oe_data;

   function automatic logic [NUM_REGS:0] onehot(input logic [SEL_W-1:0] idx);
      return (NUM_REGS+1)'(1) << idx;
   endfunction

   // src only matters for ops that read a register.
   always_comb begin
      cmd_ok = ({1'b0, dst_q} < N_LIM);
      if (op_q == OP_MOVE || op_q == OP_SWAP) begin
         cmd_ok = cmd_ok && ({1'b0, src_q} < N_LIM);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= OP_LOAD;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (state_q == IDLE && start) begin
            op_q   <= op_e'(op);
            src_q  <= src_sel;
            dst_q  <= dst_sel;
            data_q <= ext_data;
         end
         if (state_q == T1) err_q <= !cmd_ok;
      end
   end

   always_comb begin
      state_nxt = state_q;
      oe        = '0;
      ld        = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         IDLE: if (start) state_nxt = T1;
         T1: begin
            state_nxt = FIN;
            if (cmd_ok) begin
               case (op_q)
                  OP_LOAD:  ld = onehot(dst_q);
                  OP_MOVE: begin
                     oe = onehot(src_q);
                     ld = onehot(dst_q);
                  end
                  OP_CLEAR: ld = onehot(dst_q);
                  OP_SWAP: begin
                     oe        = onehot(dst_q);
                     ld        = TMP_OH;
                     state_nxt = T2;
                  end
               endcase
            end
         end
         T2: begin
            oe        = onehot(src_q);
            ld        = onehot(dst_q);
            state_nxt = T3;
         end
         T3: begin
            oe        = TMP_OH;
            ld        = onehot(src_q);
            state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // With nothing driving, the bus carries the latched LOAD value (or 0 for CLEAR).
   always_comb begin
      if (|oe)                 bus_data = oe_data;
      else if (op_q == OP_LOAD) bus_data = data_q;
      else                     bus_data = '0;
   end

   reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
   ) u_reg_bank (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .bus_data (bus_data),
      .oe       (oe),
      .oe_data  (oe_data),
      .rd_sel   (rd_sel),
      .rd_data  (rd_data)
   );

   assign busy   = (state_q != IDLE);
   assign bus_oe = oe;
   assign bus_ld = ld;

endmodule
